// File: rtl/bytewrite_ram_arb2.sv
// bytewrite_ram_arb2
// Two-requester round-robin arbiter that serialises accesses onto one
// single-port, read-first, byte-write-enable block RAM. Responses are
// routed back to the issuing requester two cycles after acceptance,
// using a small tag pipeline that runs alongside the RAM read latency.

module bytewrite_ram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int DW        = NB_COL * COL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*NB_COL-1:0]     req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DW-1:0]         req_di,

    output logic [1:0]              rsp_valid,
    output logic [DW-1:0]           rsp_do,

    output logic [NB_COL-1:0]       ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DW-1:0]           ram_di,
    input  logic [DW-1:0]           ram_do,

    output logic [CNT_WIDTH-1:0]    grant_cnt0,
    output logic [CNT_WIDTH-1:0]    grant_cnt1
);

    // Requester that won the most recent accepted access (1 = requester 1).
    logic                  last_grant;

    // Combinational winner for this cycle, one-hot or zero.
    logic [1:0]            grant;
    logic [1:0]            accept;
    logic                  accept_any;
    logic                  accept_id;

    // Winner's request fields, selected by accept_id.
    logic [NB_COL-1:0]     sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DW-1:0]         sel_di;

    // Response tag pipeline: stage 1 aligns with the RAM sampling cycle,
    // stage 2 aligns with ram_do being valid.
    logic                  tag1_valid;
    logic                  tag1_id;
    logic                  tag2_valid;
    logic                  tag2_id;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Round-robin pick: a lone requester wins; on a tie the requester that
    // was not granted last wins. Nothing is granted while reset is held.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready  = grant;
    assign accept     = req_valid & grant;
    assign accept_any = |accept;
    assign accept_id  = accept[1];

    // Route the winning requester's slice onto the issue-stage inputs.
    always_comb begin
        if (accept_id) begin
            sel_we   = req_we[2*NB_COL-1:NB_COL];
            sel_addr = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_di   = req_di[2*DW-1:DW];
        end else begin
            sel_we   = req_we[NB_COL-1:0];
            sel_addr = req_addr[ADDR_WIDTH-1:0];
            sel_di   = req_di[DW-1:0];
        end
    end

    // Remember who won last so ties alternate; only moves on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept_any) begin
            last_grant <= accept_id;
        end
    end

    // Issue stage: present the accepted request to the RAM one cycle later;
    // address and data hold when idle so the RAM port stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we   <= '0;
            ram_addr <= '0;
            ram_di   <= '0;
        end else if (accept_any) begin
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_di   <= sel_di;
        end else begin
            ram_we   <= '0;
        end
    end

    // Tag pipeline tracking which requester owns the data coming out of the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_valid <= 1'b0;
            tag1_id    <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_id    <= 1'b0;
        end else begin
            tag1_valid <= accept_any;
            tag1_id    <= accept_id;
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
        end
    end

    assign rsp_valid = tag2_valid ? (tag2_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_do    = ram_do;

    // Per-requester accepted-access counters that stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept[0] && (grant_cnt0 != CNT_MAX)) begin
                grant_cnt0 <= grant_cnt0 + CNT_ONE;
            end
            if (accept[1] && (grant_cnt1 != CNT_MAX)) begin
                grant_cnt1 <= grant_cnt1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bytewrite_ram_arb2.sv
// Testbench for bytewrite_ram_arb2: directed scenarios plus randomized
// traffic, checked against a transaction-level model (shadow memory,
// expected-response queue, saturating counters).

module tb_bytewrite_ram_arb2;

    localparam int AW = 10;
    localparam int CW = 8;
    localparam int NC = 4;
    localparam int DW = NC * CW;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*NC-1:0] req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_di;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_do;
    logic [NC-1:0]   ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_di;
    logic [DW-1:0]   ram_do;
    logic [15:0]     grant_cnt0;
    logic [15:0]     grant_cnt1;

    // Second instance with narrow counters, fed the same requests.
    logic [1:0]      s_req_ready;
    logic [1:0]      s_rsp_valid;
    logic [DW-1:0]   s_rsp_do;
    logic [NC-1:0]   s_ram_we;
    logic [AW-1:0]   s_ram_addr;
    logic [DW-1:0]   s_ram_di;
    logic [2:0]      s_cnt0;
    logic [2:0]      s_cnt1;

    bytewrite_ram_arb2 #(.ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_di(req_di),
        .rsp_valid(rsp_valid), .rsp_do(rsp_do),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    bytewrite_ram_arb2 #(.ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_di(req_di),
        .rsp_valid(s_rsp_valid), .rsp_do(s_rsp_do),
        .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_di(s_ram_di), .ram_do(32'h0),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural read-first byte-write BRAM, 16 words deep.
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        ram_do <= mem[ram_addr[3:0]];
        for (int b = 0; b < NC; b++) begin
            if (ram_we[b]) mem[ram_addr[3:0]][b*CW +: CW] <= ram_di[b*CW +: CW];
        end
    end

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [0:15];
    int            cycle;
    int            model_last;
    int            n0, n1;
    logic [NC-1:0] exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_di;

    int passed;
    int total;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cycle, actual, expected);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int maxv);
        return (n > maxv) ? 64'(maxv) : 64'(n);
    endfunction

    // One clock cycle: drive, check mid-cycle, advance the model, step the clock.
    task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [2*NC-1:0] we,
                                 input logic [2*AW-1:0] addr, input logic [2*DW-1:0] di);
        int            win;
        logic [1:0]    exp_ready;
        logic [1:0]    exp_rsp;
        logic [DW-1:0] exp_data;
        logic [NC-1:0] w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_di;
        int            a;

        rst = r; req_valid = v; req_we = we; req_addr = addr; req_di = di;
        #4;

        win = -1;
        if (!r) begin
            if (v == 2'b01) win = 0;
            else if (v == 2'b10) win = 1;
            else if (v == 2'b11) win = (model_last == 0) ? 1 : 0;
        end
        exp_ready = (win < 0) ? 2'b00 : 2'(1 << win);

        exp_rsp  = 2'b00;
        exp_data = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            exp_rsp  = 2'(1 << exp_q[0].id);
            exp_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end

        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("ram_we", 64'(ram_we), 64'(exp_we));
        checkOutput("ram_addr", 64'(ram_addr), 64'(exp_addr));
        checkOutput("ram_di", 64'(ram_di), 64'(exp_di));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp != 2'b00) checkOutput("rsp_do", 64'(rsp_do), 64'(exp_data));
        checkOutput("grant_cnt0", 64'(grant_cnt0), sat(n0, 65535));
        checkOutput("grant_cnt1", 64'(grant_cnt1), sat(n1, 65535));
        checkOutput("sat_cnt0", 64'(s_cnt0), sat(n0, 7));
        checkOutput("sat_cnt1", 64'(s_cnt1), sat(n1, 7));

        if (r) begin
            exp_q.delete();
            n0 = 0; n1 = 0;
            model_last = 1;
            exp_we = '0; exp_addr = '0; exp_di = '0;
        end else if (win >= 0) begin
            w_we   = we[win*NC +: NC];
            w_addr = addr[win*AW +: AW];
            w_di   = di[win*DW +: DW];
            a      = int'(w_addr[3:0]);
            exp_q.push_back('{due: cycle + 2, id: win, data: shadow[a]});
            for (int b = 0; b < NC; b++) begin
                if (w_we[b]) shadow[a][b*CW +: CW] = w_di[b*CW +: CW];
            end
            exp_we = w_we; exp_addr = w_addr; exp_di = w_di;
            model_last = win;
            if (win == 0) n0++; else n1++;
        end else begin
            exp_we = '0;
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, '0, '0, '0);
    endtask

    initial begin
        logic [2*NC-1:0] rwe;
        logic [2*AW-1:0] raddr;
        logic [2*DW-1:0] rdi;
        logic [1:0]      rv;

        passed = 0; total = 0; cycle = 0;
        model_last = 1; n0 = 0; n1 = 0;
        exp_we = '0; exp_addr = '0; exp_di = '0;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_di = '0;

        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] val;
            val = (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h11223344 : $urandom;
            mem[i]    <= val;
            shadow[i]  = val;
        end

        @(posedge clk);
        #1;
        doReset(3);

        // Single read of address 5 by requester 0.
        applyStimulus(1'b0, 2'b01, '0, {10'd0, 10'd5}, '0);
        idle(3);

        // Requester 1: partial byte write then read-back of address 7.
        applyStimulus(1'b0, 2'b10, {4'b0101, 4'b0000}, {10'd7, 10'd0}, {32'hAABBCCDD, 32'h0});
        applyStimulus(1'b0, 2'b10, '0, {10'd7, 10'd0}, '0);
        idle(3);

        // Contention from reset: strict alternation starting with requester 0.
        doReset(1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b11, '0, {10'd3, 10'd2}, '0);
        idle(3);
        checkOutput("contention_cnt0", 64'(grant_cnt0), 64'd4);
        checkOutput("contention_cnt1", 64'(grant_cnt1), 64'd4);

        // Requester 0 streams alone, then requester 1 joins.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b01, '0, {10'd0, 10'(i)}, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b11, '0, {10'd9, 10'd8}, '0);
        idle(3);

        // Reset with reads in flight; first tie afterwards goes to requester 0.
        applyStimulus(1'b0, 2'b01, '0, {10'd0, 10'd4}, '0);
        applyStimulus(1'b1, 2'b10, '0, {10'd6, 10'd0}, '0);
        idle(2);
        applyStimulus(1'b0, 2'b11, '0, {10'd1, 10'd2}, '0);
        idle(3);

        // Saturation of the narrow counter: ten requester-0 accesses.
        doReset(1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b01, '0, {10'd0, 10'(i)}, '0);
        idle(3);
        checkOutput("sat_hold_cnt0", 64'(s_cnt0), 64'd7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rv    = 2'($urandom_range(0, 3));
            rwe   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            raddr = {10'($urandom_range(0, 15)), 10'($urandom_range(0, 15))};
            rdi   = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 49) == 0), rv, rwe, raddr, rdi);
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
